// File: rtl/if_fetch_stall_pkg.sv
// Shared IF-stage definitions: fetch FSM encoding, bubble instruction and
// PC increment helper used by the fetch engine and the IF/ID register.
package if_fetch_stall_pkg;

    typedef logic [2:0] fetch_state_t;

    localparam fetch_state_t IDLE      = 3'd0;
    localparam fetch_state_t REQ       = 3'd1;
    localparam fetch_state_t WAIT      = 3'd2;
    localparam fetch_state_t WAIT_DROP = 3'd3;
    localparam fetch_state_t FULL      = 3'd4;

    // addi x0,x0,0
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    function automatic logic [31:0] pc_inc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/if_fetch_stall_buf.sv
// One-entry fetch buffer holding a returned instruction and its PC.
// Ports: fill_i/fill_pc_i/fill_inst_i load, consume_i drains, flush_i clears;
// valid_o/pc_o/inst_o present the held entry.
module if_fetch_stall_buf #(
    parameter logic [31:0] INST_RST = 32'h0000_0013
) (
    input  logic        clk_IFID,
    input  logic        rst_IFID,
    input  logic        flush_i,
    input  logic        fill_i,
    input  logic [31:0] fill_pc_i,
    input  logic [31:0] fill_inst_i,
    input  logic        consume_i,
    output logic        valid_o,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o
);

    logic        valid_q;
    logic        valid_d;
    logic [31:0] pc_q;
    logic [31:0] inst_q;

    // A fill in the same cycle as a consume keeps the entry valid.
    always_comb begin
        valid_d = valid_q;
        if (flush_i)
            valid_d = 1'b0;
        else if (fill_i)
            valid_d = 1'b1;
        else if (consume_i)
            valid_d = 1'b0;
    end

    always_ff @(posedge clk_IFID or posedge rst_IFID) begin
        if (rst_IFID) begin
            valid_q <= 1'b0;
            pc_q    <= 32'd0;
            inst_q  <= INST_RST;
        end else begin
            valid_q <= valid_d;
            if (fill_i) begin
                pc_q   <= fill_pc_i;
                inst_q <= fill_inst_i;
            end
        end
    end

    assign valid_o = valid_q;
    assign pc_o    = pc_q;
    assign inst_o  = inst_q;

endmodule

// File: rtl/if_fetch_stall.sv
// IF-stage fetch engine: owns the PC, issues single-outstanding imem requests,
// buffers one instruction and drives the IF/ID stall register inputs.
// Ports: stall_IF/redirect_* from hazard/EX, imem_* req/gnt/rvalid fetch port,
// PC_in_IFID/inst_in_IFID/en_IFID/NOP_IFID toward the IF/ID register.
module if_fetch_stall #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = if_fetch_stall_pkg::NOP_INST
) (
    input  logic        clk_IFID,
    input  logic        rst_IFID,
    input  logic        stall_IF,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] PC_in_IFID,
    output logic [31:0] inst_in_IFID,
    output logic        en_IFID,
    output logic        NOP_IFID
);

    import if_fetch_stall_pkg::*;

    fetch_state_t state_q;
    fetch_state_t state_d;
    logic [31:0]  pc_q;
    logic [31:0]  pc_d;
    logic [31:0]  req_pc_q;
    logic [31:0]  req_pc_d;

    logic        buf_valid;
    logic [31:0] buf_pc;
    logic [31:0] buf_inst;
    logic        fire;
    logic        fill;
    logic        can_issue;
    logic        gnt_ok;
    logic        unused_align;

    assign unused_align = ^redirect_pc[1:0];

    assign fire = buf_valid & ~stall_IF & ~redirect_valid;

    // A request may only be raised when its response is guaranteed a free
    // buffer slot, and never while IF is held.
    assign can_issue = ~stall_IF & (~buf_valid | fire | ~redirect_valid)
                     & (~buf_valid | fire);

    assign imem_req  = (state_q == REQ) & can_issue;
    assign imem_addr = pc_q;
    assign gnt_ok    = imem_req & imem_gnt;

    // Responses are only kept in WAIT; a redirect turns them stale.
    assign fill = imem_rvalid & (state_q == WAIT) & ~redirect_valid;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        if (gnt_ok) begin
            req_pc_d = pc_q;
            pc_d     = pc_inc(pc_q);
        end
        if (redirect_valid)
            pc_d = {redirect_pc[31:2], 2'b00};
        unique case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                if (redirect_valid)
                    state_d = gnt_ok ? WAIT_DROP : REQ;
                else if (gnt_ok)
                    state_d = WAIT;
                else if (buf_valid & ~fire)
                    state_d = FULL;
            end
            WAIT: begin
                if (imem_rvalid)
                    state_d = (redirect_valid | ~stall_IF) ? REQ : FULL;
                else if (redirect_valid)
                    state_d = WAIT_DROP;
            end
            WAIT_DROP: begin
                if (imem_rvalid)
                    state_d = REQ;
            end
            FULL: begin
                if (redirect_valid | fire)
                    state_d = REQ;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_IFID or posedge rst_IFID) begin
        if (rst_IFID) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            req_pc_q <= RESET_PC;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
        end
    end

    if_fetch_stall_buf #(
        .INST_RST(NOP_INST)
    ) u_buf (
        .clk_IFID   (clk_IFID),
        .rst_IFID   (rst_IFID),
        .flush_i    (redirect_valid),
        .fill_i     (fill),
        .fill_pc_i  (req_pc_q),
        .fill_inst_i(imem_rdata),
        .consume_i  (fire),
        .valid_o    (buf_valid),
        .pc_o       (buf_pc),
        .inst_o     (buf_inst)
    );

    assign PC_in_IFID   = buf_pc;
    assign inst_in_IFID = buf_valid ? buf_inst : NOP_INST;
    assign en_IFID      = ~rst_IFID & ~stall_IF;
    assign NOP_IFID     = ~rst_IFID & (redirect_valid | (~stall_IF & ~buf_valid));

    a_rvalid_in_wait: assert property (
        @(posedge clk_IFID) disable iff (rst_IFID)
        imem_rvalid |-> (state_q == WAIT || state_q == WAIT_DROP));

    a_rvalid_room: assert property (
        @(posedge clk_IFID) disable iff (rst_IFID)
        (imem_rvalid && state_q == WAIT) |-> (!buf_valid || fire));

endmodule
